// File: rtl/array_loader_n_m.sv
// Serial-to-array loader: collects n-bit words over valid/ready into an (m+1)-entry
// array, index 0 first, and holds the complete frame until the consumer releases it.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting words, one per cycle, into arr_o[idx_o]
// FULL  | all m+1 entries written; frame frozen until release_i or clr_i
module array_loader_n_m #(
    parameter int n     = 4,
    parameter int m     = 15,
    parameter int value = 0,
    localparam int IW   = (m + 1 > 1) ? $clog2(m + 1) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [n-1:0]  data_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          clr_i,
    input  logic          release_i,
    output logic [n-1:0]  arr_o [0:m],
    output logic [IW-1:0] idx_o,
    output logic          full_o,
    output logic          done_o
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [n-1:0]  CLR_VAL  = value[n-1:0];
    localparam logic [IW-1:0] IDX_LAST = IW'(m);

    state_t state;

    // ready_o and full_o are registered copies of the state decode so that
    // no input reaches an output combinationally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= FILL;
            idx_o   <= '0;
            ready_o <= 1'b1;
            full_o  <= 1'b0;
            done_o  <= 1'b0;
            for (int i = 0; i <= m; i++) begin
                arr_o[i] <= CLR_VAL;
            end
        end else begin
            done_o <= 1'b0;
            if (clr_i) begin
                state   <= FILL;
                idx_o   <= '0;
                ready_o <= 1'b1;
                full_o  <= 1'b0;
                for (int i = 0; i <= m; i++) begin
                    arr_o[i] <= CLR_VAL;
                end
            end else begin
                case (state)
                    FILL: begin
                        if (valid_i) begin
                            arr_o[idx_o] <= data_i;
                            if (idx_o == IDX_LAST) begin
                                idx_o   <= '0;
                                state   <= FULL;
                                ready_o <= 1'b0;
                                full_o  <= 1'b1;
                                done_o  <= 1'b1;
                            end else begin
                                idx_o <= idx_o + 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        // Frame is retained on release; later accepts overwrite it in place.
                        if (release_i) begin
                            state   <= FILL;
                            ready_o <= 1'b1;
                            full_o  <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= FILL;
                        ready_o <= 1'b1;
                        full_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_array_loader_n_m.sv
// Directed bench for array_loader_n_m: dense/gapped fills, FULL hold, release,
// clear priority, value=9 clear build and asynchronous mid-frame reset.
module tb_array_loader_n_m;

    logic       clk;
    logic       rst;
    logic [3:0] data;
    logic       valid;
    logic       clr;
    logic       rel;

    logic       ready,  full,  done;
    logic [3:0] idx;
    logic [3:0] arr  [0:15];
    logic       ready9, full9, done9;
    logic [3:0] idx9;
    logic [3:0] arr9 [0:15];

    logic [3:0] exp_arr [0:15];
    int total;
    int bad;
    int done_cnt;

    array_loader_n_m #(.n(4), .m(15), .value(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
        .clr_i(clr), .release_i(rel), .arr_o(arr), .idx_o(idx), .full_o(full), .done_o(done)
    );

    array_loader_n_m #(.n(4), .m(15), .value(9)) u_dut9 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready9),
        .clr_i(clr), .release_i(rel), .arr_o(arr9), .idx_o(idx9), .full_o(full9), .done_o(done9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_arr(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_arr%0d", tag, i), 32'(arr[i]), 32'(exp_arr[i]));
        end
    endtask

    task automatic set_exp_all(input logic [3:0] v);
        for (int i = 0; i < 16; i++) exp_arr[i] = v;
    endtask

    task automatic load_dense(input int count);
        for (int i = 0; i < count; i++) begin
            data  = 4'((i + 1) & 4'hF);
            valid = 1'b1;
            tick();
        end
        valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; data = '0; valid = 1'b0; clr = 1'b0; rel = 1'b0;

        // reset state
        #12;
        set_exp_all(4'h0);
        chk_arr("rst");
        chk("rst_idx", 32'(idx), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_done", 32'(done), 0);
        for (int i = 0; i < 16; i++) chk($sformatf("rst9_arr%0d", i), 32'(arr9[i]), 9);
        rst = 1'b1;

        // 1: dense fill of 16 words
        load_dense(15);
        chk("t1_idx15", 32'(idx), 15);
        chk("t1_done_early", 32'(done), 0);
        chk("t1_full_early", 32'(full), 0);
        data = 4'h0; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 16; i++) exp_arr[i] = 4'((i + 1) & 4'hF);
        chk_arr("t1");
        chk("t1_done", 32'(done), 1);
        chk("t1_full", 32'(full), 1);
        chk("t1_ready", 32'(ready), 0);
        chk("t1_idx", 32'(idx), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_full_hold", 32'(full), 1);

        // 2: valid ignored in FULL, then release
        data = 4'hA; valid = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        valid = 1'b0;
        chk_arr("t2_hold");
        chk("t2_idx", 32'(idx), 0);
        chk("t2_done", 32'(done), 0);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("t2_ready", 32'(ready), 1);
        chk("t2_full", 32'(full), 0);
        chk("t2_idx_rel", 32'(idx), 0);
        data = 4'h5; valid = 1'b1;
        tick();
        valid = 1'b0;
        exp_arr[0] = 4'h5;
        chk_arr("t2_ovw");
        chk("t2_idx1", 32'(idx), 1);

        // 3: gapped fill after a clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_exp_all(4'h0);
        chk_arr("t3_clr");
        chk("t3_clr_idx", 32'(idx), 0);
        done_cnt = 0;
        for (int w = 0; w < 16; w++) begin
            data = 4'((w + 1) & 4'hF); valid = 1'b1;
            tick();
            done_cnt += int'(done);
            chk($sformatf("t3_idx_w%0d", w), 32'(idx), 32'((w + 1) & 15));
            valid = 1'b0;
            for (int g = 0; g < 2; g++) begin
                tick();
                done_cnt += int'(done);
                if (w < 15) chk($sformatf("t3_idle_idx_w%0d", w), 32'(idx), 32'(w + 1));
            end
        end
        for (int i = 0; i < 16; i++) exp_arr[i] = 4'((i + 1) & 4'hF);
        chk_arr("t3");
        chk("t3_done_cnt", 32'(done_cnt), 1);
        chk("t3_full", 32'(full), 1);

        // 4: clear beats a same-cycle accept; value=9 build clears to 9
        rel = 1'b1;
        tick();
        rel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            data = 4'(i + 3); valid = 1'b1;
            tick();
        end
        chk("t4_idx7", 32'(idx), 7);
        data = 4'hE; valid = 1'b1; clr = 1'b1;
        tick();
        valid = 1'b0; clr = 1'b0;
        set_exp_all(4'h0);
        chk_arr("t4");
        chk("t4_idx", 32'(idx), 0);
        chk("t4_ready", 32'(ready), 1);
        chk("t4_full", 32'(full), 0);
        for (int i = 0; i < 16; i++) chk($sformatf("t4v9_arr%0d", i), 32'(arr9[i]), 9);
        chk("t4v9_idx", 32'(idx9), 0);

        // 5: asynchronous reset mid-frame, then clr+release in FULL
        load_dense(10);
        chk("t5_idx10", 32'(idx), 10);
        #2 rst = 1'b0;
        #1;
        chk_arr("t5_async");
        chk("t5_async_idx", 32'(idx), 0);
        chk("t5_async_ready", 32'(ready), 1);
        chk("t5_async_full", 32'(full), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        load_dense(16);
        chk("t5_full", 32'(full), 1);
        clr = 1'b1; rel = 1'b1;
        tick();
        clr = 1'b0; rel = 1'b0;
        chk_arr("t5_clrrel");
        chk("t5_clrrel_full", 32'(full), 0);
        chk("t5_clrrel_ready", 32'(ready), 1);
        chk("t5_clrrel_idx", 32'(idx), 0);
        chk("t5_clrrel_done", 32'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
